// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
//   Bundles the processor-side controls and display-side outputs of the
//   7-segment scan controller.
//   enable     : 1 = scan, 0 = display dark and scan restarts
//   value      : 16-bit word to show, value[3:0] is digit0 (rightmost)
//   load       : 1-cycle strobe, capture value for commit at next frame boundary
//   dp_mask    : dp_mask[k]=1 lights the decimal point of digit k
//   an         : anode enables, active-low
//   out        : segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_done : 1-cycle pulse at each frame boundary
//   master drives the controls; slave (the controller) drives the display side.
interface seg7_scan_ctrl_if;
    logic        enable;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [7:0]  out;
    logic        frame_done;

    modport master (
        output enable, value, load, dp_mask,
        input  an, out, frame_done
    );

    modport slave (
        input  enable, value, load, dp_mask,
        output an, out, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. Each digit gets a BLANK gap (all anodes off) followed by a DRIVE
//   slot. A loaded value is held in a pending register and committed to the
//   displayed shadow register only at the frame boundary (end of digit 3
//   DRIVE), so a frame never mixes old and new digits.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : seg7_scan_ctrl_if.slave (enable, value, load, dp_mask in;
//             an, out, frame_done out, all outputs registered)
//   Optional feature macro: SEG7_LZ_BLANK_EN enables leading-zero suppression
//   (digits above the most significant non-zero nibble stay dark unless their
//   decimal point is lit; digit0 is always lit).
module seg7_scan_ctrl #(
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_TICKS     = 1000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t           state;
    logic [1:0]       digit;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      shadow;
    logic [15:0]      pending;
    logic             pend_v;
    logic [3:0]       an_q;
    logic [7:0]       out_q;
    logic             frame_done_q;

    logic [3:0]       nib;
    logic [3:0]       lit_an;
    logic [7:0]       lit_out;
    logic             last_drive;

    function automatic logic [6:0] seg7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Anode/segment pattern for the current digit while it is lit.
    // dp_mask is used live so the decimal points react without waiting a frame.
    always_comb begin
        nib     = shadow[{digit, 2'b00} +: 4];
        lit_an  = ~(4'b0001 << digit);
        lit_out = {~bus.dp_mask[digit], seg7(nib)};
`ifdef SEG7_LZ_BLANK_EN
        if ((digit != 2'd0) && ((shadow >> {digit, 2'b00}) == 16'h0000)
                && !bus.dp_mask[digit]) begin
            lit_an  = '1;
            lit_out = '1;
        end
`endif
    end

    assign last_drive = (state == DRIVE) && (digit == 2'd3) && (cnt == DRIVE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BLANK;
            digit        <= '0;
            cnt          <= '0;
            shadow       <= '0;
            pending      <= '0;
            pend_v       <= 1'b0;
            an_q         <= '1;
            out_q        <= '1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!bus.enable) begin
                state <= BLANK;
                digit <= '0;
                cnt   <= '0;
                an_q  <= '1;
                out_q <= '1;
                // Display is dark, so there is no frame to protect: pending
                // flows into shadow one cycle after it is captured.
                if (pend_v) begin
                    shadow <= pending;
                    pend_v <= 1'b0;
                end
                if (bus.load) begin
                    pending <= bus.value;
                    pend_v  <= 1'b1;
                end
            end else begin
                if (last_drive) begin
                    frame_done_q <= 1'b1;
                    // A load landing on the boundary edge bypasses pending.
                    if (bus.load) begin
                        shadow  <= bus.value;
                        pending <= bus.value;
                        pend_v  <= 1'b0;
                    end else if (pend_v) begin
                        shadow <= pending;
                        pend_v <= 1'b0;
                    end
                end else if (bus.load) begin
                    pending <= bus.value;
                    pend_v  <= 1'b1;
                end

                case (state)
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            cnt   <= '0;
                            state <= DRIVE;
                            an_q  <= lit_an;
                            out_q <= lit_out;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            an_q  <= '1;
                            out_q <= '1;
                        end
                    end
                    DRIVE: begin
                        if (cnt == DRIVE_LAST) begin
                            cnt   <= '0;
                            state <= BLANK;
                            digit <= digit + 2'd1;
                            an_q  <= '1;
                            out_q <= '1;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            an_q  <= lit_an;
                            out_q <= lit_out;
                        end
                    end
                    default: begin
                        state <= BLANK;
                        cnt   <= '0;
                        an_q  <= '1;
                        out_q <= '1;
                    end
                endcase
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.out        = out_q;
    assign bus.frame_done = frame_done_q;

endmodule
